// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer:
// opcodes, FSM states, immediate selects and instruction classes.
package ctrl_pkg;

  localparam logic [3:0] OP_ALU_MAX = 4'h5;
  localparam logic [3:0] OP_ADDI    = 4'h6;
  localparam logic [3:0] OP_LOAD    = 4'h7;
  localparam logic [3:0] OP_STORE   = 4'h8;
  localparam logic [3:0] OP_SHIFTI  = 4'h9;
  localparam logic [3:0] OP_LI      = 4'hA;
  localparam logic [3:0] OP_BEQ     = 4'hB;
  localparam logic [3:0] OP_BNE     = 4'hC;
  localparam logic [3:0] OP_JMP     = 4'hD;
  localparam logic [3:0] OP_NOP     = 4'hE;
  localparam logic [3:0] OP_HALT    = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    IMM_I  = 2'b00,
    IMM_S  = 2'b01,
    IMM_B  = 2'b10,
    IMM_LI = 2'b11
  } imm_src_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_IMM,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_NOP,
    C_HALT
  } op_class_e;

  function automatic logic exec_retires(input op_class_e c);
    return c inside {C_BRANCH, C_JUMP, C_NOP};
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of the latched opcode into instruction
// class and immediate-operand controls.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] ir_op_i,
  output op_class_e  op_class_o,
  output logic       alu_src_o,
  output imm_src_e   imm_src_o
);

  always_comb begin
    op_class_o = C_NOP;
    alu_src_o  = 1'b0;
    imm_src_o  = IMM_I;
    unique case (1'b1)
      (ir_op_i <= OP_ALU_MAX): begin
        op_class_o = C_ALU;
      end
      (ir_op_i == OP_ADDI),
      (ir_op_i == OP_SHIFTI): begin
        op_class_o = C_IMM;
        alu_src_o  = 1'b1;
      end
      (ir_op_i == OP_LI): begin
        op_class_o = C_IMM;
        alu_src_o  = 1'b1;
        imm_src_o  = IMM_LI;
      end
      (ir_op_i == OP_LOAD): begin
        op_class_o = C_LOAD;
        alu_src_o  = 1'b1;
      end
      (ir_op_i == OP_STORE): begin
        op_class_o = C_STORE;
        alu_src_o  = 1'b1;
        imm_src_o  = IMM_S;
      end
      (ir_op_i == OP_BEQ),
      (ir_op_i == OP_BNE): begin
        op_class_o = C_BRANCH;
        imm_src_o  = IMM_B;
      end
      (ir_op_i == OP_JMP): begin
        op_class_o = C_JUMP;
        imm_src_o  = IMM_B;
      end
      (ir_op_i == OP_NOP): begin
        op_class_o = C_NOP;
      end
      (ir_op_i == OP_HALT): begin
        op_class_o = C_HALT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with
// run/step host control, sticky halt and retire counter.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic [3:0]         opcode,
  input  logic               branch_taken,
  output logic               ResultSrc,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               ALUSrc,
  output logic [1:0]         ImmSrc,
  output logic               RegWrite,
  output logic               Branch,
  output logic               Jump,
  output logic               PCSrc,
  output logic               pc_en,
  output logic               halted,
  output logic [2:0]         state_out,
  output logic [COUNT_W-1:0] instr_count
);

  localparam int MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_LAT - 1);

  state_e             state_q, state_d;
  logic [3:0]         ir_op_q, ir_op_d;
  logic [MCW-1:0]     mem_cnt_q, mem_cnt_d;
  logic [COUNT_W-1:0] count_q, count_d;

  op_class_e op_class;
  logic      alu_src;
  imm_src_e  imm_src;

  logic in_exec, in_mem, in_wb;
  logic mem_last, imm_phase, retire;

  control_decoder u_dec (
    .ir_op_i    (ir_op_q),
    .op_class_o (op_class),
    .alu_src_o  (alu_src),
    .imm_src_o  (imm_src)
  );

  assign in_exec   = (state_q == S_EXEC);
  assign in_mem    = (state_q == S_MEM);
  assign in_wb     = (state_q == S_WB);
  assign mem_last  = (mem_cnt_q == MEM_LAST);
  assign imm_phase = in_exec | in_mem | in_wb;

  // An instruction retires in exactly one of these three places.
  assign retire = (in_exec & exec_retires(op_class))
                | (in_mem & (op_class == C_STORE) & mem_last)
                | in_wb;

  always_comb begin
    state_d   = state_q;
    ir_op_d   = ir_op_q;
    mem_cnt_d = mem_cnt_q;
    count_d   = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_op_d = opcode;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (op_class == C_HALT) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        unique case (op_class)
          C_LOAD, C_STORE: begin
            state_d   = S_MEM;
            mem_cnt_d = '0;
          end
          C_ALU, C_IMM: state_d = S_WB;
          default: ;
        endcase
      end
      S_MEM: begin
        if (!mem_last) begin
          mem_cnt_d = mem_cnt_q + MCW'(1);
        end else if (op_class == C_LOAD) begin
          state_d = S_WB;
        end
      end
      S_WB, S_HALT: ;
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      count_d = count_q + COUNT_W'(1);
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_op_q   <= OP_NOP;
      mem_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      ir_op_q   <= ir_op_d;
      mem_cnt_q <= mem_cnt_d;
      count_q   <= count_d;
    end
  end

  // Moore decode from the registered state; reset clears it at once.
  assign MemRead   = in_mem & (op_class == C_LOAD);
  assign MemWrite  = in_mem & (op_class == C_STORE);
  assign RegWrite  = in_wb;
  assign ResultSrc = in_wb & (op_class == C_LOAD);
  assign ALUSrc    = imm_phase & alu_src;
  assign ImmSrc    = imm_phase ? imm_src : IMM_I;
  assign Branch    = in_exec & (op_class == C_BRANCH);
  assign Jump      = in_exec & (op_class == C_JUMP);
  assign PCSrc     = Jump | (Branch & branch_taken);
  assign pc_en     = retire;
  assign halted    = (state_q == S_HALT);
  assign state_out = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected
// per-instruction profile, a negedge monitor checks it at each retire.
module tb_control_sequencer;

  localparam int COUNT_W = 4;
  localparam int MEM_LAT = 3;

  logic clk = 1'b0;
  logic reset, run, step, branch_taken;
  logic [3:0] opcode;
  logic ResultSrc, MemRead, MemWrite, ALUSrc;
  logic [1:0] ImmSrc;
  logic RegWrite, Branch, Jump, PCSrc, pc_en, halted;
  logic [2:0] state_out;
  logic [COUNT_W-1:0] instr_count;

  control_sequencer #(
    .COUNT_W (COUNT_W),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .ResultSrc    (ResultSrc),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ALUSrc       (ALUSrc),
    .ImmSrc       (ImmSrc),
    .RegWrite     (RegWrite),
    .Branch       (Branch),
    .Jump         (Jump),
    .PCSrc        (PCSrc),
    .pc_en        (pc_en),
    .halted       (halted),
    .state_out    (state_out),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [31:0] seq;
    int          rw;
    int          mr;
    int          mw;
    bit          pcs;
    bit          rsrc;
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  int errors = 0;
  int checks = 0;
  int retires = 0;
  int exp_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Monitor: profile each instruction from FETCH to its retire pulse.
  initial begin
    bit          trk;
    int          lat, rw, mr, mw;
    bit          pcs, rsrc;
    logic [31:0] seq;
    logic [2:0]  last_st;
    exp_t        e;
    trk = 0; lat = 0; rw = 0; mr = 0; mw = 0;
    pcs = 0; rsrc = 0; seq = 0; last_st = 3'd7;
    forever begin
      @(negedge clk);
      if (reset) begin
        trk = 0;
      end else begin
        if (state_out == 3'd1) begin
          trk = 1; lat = 0; rw = 0; mr = 0; mw = 0;
          pcs = 0; rsrc = 0; seq = 0; last_st = 3'd7;
        end
        if (trk) begin
          lat++;
          if (state_out != last_st) begin
            seq = (seq << 4) | 32'(state_out);
            last_st = state_out;
          end
          rw += int'(RegWrite);
          mr += int'(MemRead);
          mw += int'(MemWrite);
          if (PCSrc && state_out == 3'd3) pcs = 1;
          if (ResultSrc && RegWrite) rsrc = 1;
        end
        if (pc_en) begin
          retires++;
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL retire: unexpected pc_en in state %0d, none required", state_out);
          end else begin
            e = sbq.pop_front();
            chk("latency", lat, e.lat);
            chk("state_seq", seq, e.seq);
            chk("regwrite_cycles", rw, e.rw);
            chk("memread_cycles", mr, e.mr);
            chk("memwrite_cycles", mw, e.mw);
            chk("pcsrc", pcs, e.pcs);
            chk("resultsrc", rsrc, e.rsrc);
            chk("count_at_retire", instr_count, e.cnt);
          end
          trk = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (state_out != s && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(nm, state_out, s);
  endtask

  task automatic push_exp(input int lat, input logic [31:0] seq,
                          input int rw, input int mr, input int mw,
                          input bit pcs, input bit rsrc);
    exp_t e;
    e.lat = lat; e.seq = seq; e.rw = rw; e.mr = mr; e.mw = mw;
    e.pcs = pcs; e.rsrc = rsrc; e.cnt = exp_cnt;
    exp_cnt = (exp_cnt + 1) % 16;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input bit bt,
                       input int lat, input logic [31:0] seq,
                       input int rw, input int mr, input int mw,
                       input bit pcs, input bit rsrc);
    wait_state(3'd1, "reach_fetch");
    opcode = op;
    branch_taken = bt;
    push_exp(lat, seq, rw, mr, mw, pcs, rsrc);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; run = 1'b0; step = 1'b0;
    opcode = 4'h0; branch_taken = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", state_out, 0);
    chk("reset_ctrl", {ResultSrc, MemRead, MemWrite, ALUSrc, ImmSrc,
                       RegWrite, Branch, Jump, PCSrc, pc_en}, 0);
    chk("reset_halted", halted, 0);
    chk("reset_count", instr_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single-step an ALU op
    opcode = 4'h0;
    push_exp(4, 32'h1235, 1, 0, 0, 0, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_state(3'd0, "idle_after_step");
    chk("count_after_step", instr_count, 1);
    repeat (3) @(negedge clk);
    chk("idle_holds", state_out, 0);

    // Continuous run across all classes
    run = 1'b1;
    issue(4'h7, 0, 7, 32'h12345, 1, 3, 0, 0, 1);
    issue(4'h8, 0, 6, 32'h1234,  0, 0, 3, 0, 0);
    issue(4'hB, 1, 3, 32'h123,   0, 0, 0, 1, 0);
    issue(4'hB, 0, 3, 32'h123,   0, 0, 0, 0, 0);
    issue(4'hC, 1, 3, 32'h123,   0, 0, 0, 1, 0);
    issue(4'hD, 0, 3, 32'h123,   0, 0, 0, 1, 0);
    issue(4'h6, 0, 4, 32'h1235,  1, 0, 0, 0, 0);
    issue(4'hA, 0, 4, 32'h1235,  1, 0, 0, 0, 0);
    issue(4'hE, 0, 3, 32'h123,   0, 0, 0, 0, 0);
    @(negedge clk);
    chk("in_exec_at_run_drop", state_out, 3);
    run = 1'b0;
    @(negedge clk);
    chk("idle_after_run_drop", state_out, 0);
    chk("count_after_run", instr_count, 10);

    // 16 NOPs wrap the 4-bit counter through 15 -> 0
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(4'hE, 0, 3, 32'h123, 0, 0, 0, 0, 0);
      if (i == 15) run = 1'b0;
    end
    wait_state(3'd0, "idle_after_wrap");
    chk("count_after_wrap", instr_count, 10);

    // Reset asserted mid-WB of an ALU op
    opcode = 4'h3;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state_out != 3'd5 && n < 20);
    chk("reach_wb", state_out, 5);
    chk("regwrite_in_wb", RegWrite, 1);
    reset = 1'b1;
    #1;
    chk("regwrite_async_clear", RegWrite, 0);
    chk("state_async_clear", state_out, 0);
    chk("count_async_clear", instr_count, 0);
    chk("pc_en_async_clear", pc_en, 0);
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;

    // HALT under run is sticky
    run = 1'b1;
    issue(4'h6, 0, 4, 32'h1235, 1, 0, 0, 0, 0);
    wait_state(3'd1, "reach_fetch_halt");
    opcode = 4'hF;
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("halt_state", state_out, 6);
    chk("halt_flag", halted, 1);
    chk("halt_count", instr_count, 1);
    chk("halt_ctrl", {ResultSrc, MemRead, MemWrite, ALUSrc, ImmSrc,
                      RegWrite, Branch, Jump, PCSrc, pc_en}, 0);
    run = 1'b0;
    repeat (2) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      @(negedge clk);
    end
    chk("halt_ignores_step", state_out, 6);
    chk("halt_count_steady", instr_count, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("halt_cleared", halted, 0);
    chk("state_after_halt_reset", state_out, 0);
    reset = 1'b0;
    @(negedge clk);

    chk("scoreboard_drained", sbq.size(), 0);
    chk("total_retires", retires, 27);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
